// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width and FSM state type.
package nibble_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/bit4_adder.sv
// One 4-bit ripple adder slice; the only arithmetic on the serial adder's operand path.
module bit4_adder (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {4'b0000, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// Adds two W-bit operands one nibble per clock, LSB nibble first, using one bit4_adder.
// Optional subtract mode (b inverted, carry forced to 1) is built when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; sum and c_out hold the last result
// RUN   | committing nibble idx each clock, last nibble returns to IDLE with done
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  input  logic                         c_in,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic                         sub,
`endif
  output logic                         busy,
  output logic                         done,
  output logic [NIBBLE_W*NIBBLES-1:0]  sum,
  output logic                         c_out
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t              state;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic                carry_q;
  logic [IDX_W-1:0]    idx;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_s;
  logic                nib_co;
  logic [W-1:0]        sum_next;
  logic [W-1:0]        b_load;
  logic                carry_load;
  logic                last;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  // a - b as a + ~b + 1, so c_out=1 means no borrow
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : c_in;
`else
  assign b_load     = b;
  assign carry_load = c_in;
`endif

  assign busy = (state == RUN);
  assign last = (idx == IDX_W'(NIBBLES - 1));

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == IDX_W'(n)) begin
        nib_a = a_q[n*NIBBLE_W +: NIBBLE_W];
        nib_b = b_q[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  bit4_adder u_bit4_adder (
    .x  (nib_a),
    .y  (nib_b),
    .ci (carry_q),
    .s  (nib_s),
    .co (nib_co)
  );

  always_comb begin
    sum_next = sum;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == IDX_W'(n)) begin
        sum_next[n*NIBBLE_W +: NIBBLE_W] = nib_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      c_out   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b_load;
            carry_q <= carry_load;
            idx     <= '0;
            sum     <= '0;
            c_out   <= 1'b0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum     <= sum_next;
          carry_q <= nib_co;
          if (last) begin
            idx   <= '0;
            c_out <= nib_co;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
